store_issue: RTL and testbench

- Memory-stage store path: the write-side counterpart of the load-data extraction done at writeback.
- Takes a store request (address, raw rs2 data, msize) from the memory stage and shifts the data into its 64-bit lane.
- Generates the byte strobe, detects store misalignment, and runs a valid/addr_ok/data_ok handshake on the data bus.
- Stalls the pipeline until the write completes, or until the request is dropped by flush or timeout.

---
 rtl/store_issue.sv | 218 +++++++++++++++++++++
 tb/tb_store_issue.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_issue.sv
`default_nettype none
// ============================================================================
// Module   : store_issue
// Purpose  : Memory-stage store path. Shifts raw rs2 store data into its
//            64-bit lane, builds the byte strobe, detects misaligned stores,
//            and runs a valid / addr_ok / data_ok handshake on the data bus.
//            The memory stage is stalled until the write completes, or until
//            the request is dropped by a flush or a bus timeout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYCLES : REQ cycles without data_ok before a bus-error abort;
//                    0 disables the timeout counter.
// Ports
//   clk            in   1  core clock
//   reset          in   1  synchronous, active-high reset
//   req_valid      in   1  memory stage has a store this cycle
//   req_addr       in  64  effective address
//   req_data       in  64  unshifted store data, low bytes significant
//   req_msize      in   2  0=byte 1=half 2=word 3=double
//   flush          in   1  pipeline flush
//   dreq_valid     out  1  bus request valid
//   dreq_addr      out 64  request address
//   dreq_size      out  3  log2 bytes
//   dreq_strobe    out  8  byte write enables
//   dreq_data      out 64  lane-aligned write data
//   dresp_addr_ok  in   1  bus accepted address
//   dresp_data_ok  in   1  bus completed write
//   stall          out  1  hold the memory stage
//   done           out  1  one-cycle pulse: store committed
//   st_misalign    out  1  store misalignment exception (IDLE only)
//   bus_err        out  1  one-cycle pulse: timeout abort
// ============================================================================
module store_issue #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_data,
    input  logic [1:0]  req_msize,
    input  logic        flush,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    output logic        stall,
    output logic        done,
    output logic        st_misalign,
    output logic        bus_err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]  r_state;
    logic        r_accepted;
    logic        r_valid;
    logic [63:0] r_addr;
    logic [63:0] r_data;
    logic [7:0]  r_strobe;
    logic [2:0]  r_size;
    logic        r_done;
    logic        r_bus_err;

    logic [2:0]  w_off;
    logic [63:0] w_lane_data;
    logic [7:0]  w_strobe_base;
    logic [7:0]  w_lane_strobe;
    logic        w_misalign;
    logic        w_idle;
    logic        w_in_req;
    logic        w_take;
    logic        w_expire;

    // ------------------------------------------------------------------
    // Lane formation and alignment check, straight off the request inputs
    // ------------------------------------------------------------------
    assign w_off       = req_addr[2:0];
    assign w_lane_data = req_data << {w_off, 3'b000};

    always_comb begin
        w_strobe_base = 8'h01;
        w_misalign    = 1'b0;
        case (req_msize)
            2'd0: begin
                w_strobe_base = 8'h01;
                w_misalign    = 1'b0;
            end
            2'd1: begin
                w_strobe_base = 8'h03;
                w_misalign    = w_off[0];
            end
            2'd2: begin
                w_strobe_base = 8'h0F;
                w_misalign    = (w_off[1:0] != 2'b00);
            end
            default: begin
                w_strobe_base = 8'hFF;
                w_misalign    = (w_off != 3'b000);
            end
        endcase
    end

    assign w_lane_strobe = w_strobe_base << w_off;

    assign w_idle   = (r_state == c_st_idle);
    assign w_in_req = (r_state == c_st_req);

    // A flushed request is ignored entirely, including its exception.
    assign w_take      = w_idle & req_valid & ~w_misalign & ~flush & ~reset;
    assign st_misalign = w_idle & req_valid &  w_misalign & ~flush & ~reset;

    // The stall rises in the same cycle the request is taken so the memory
    // stage holds the instruction while the bus transaction is pending.
    assign stall = w_take | (w_in_req & ~reset);

    // ------------------------------------------------------------------
    // Optional bus timeout
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

            logic [c_cnt_w-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (w_take) begin
                    r_cnt <= '0;
                end else if (w_in_req && !dresp_data_ok) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            // Expiry is the last waiting cycle; data_ok in that cycle wins.
            assign w_expire = w_in_req & ~dresp_data_ok & (r_cnt == c_cnt_last);
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Store FSM with registered bus fields and pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_accepted <= 1'b0;
            r_valid    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_strobe   <= '0;
            r_size     <= '0;
            r_done     <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_take) begin
                        r_state    <= c_st_req;
                        r_valid    <= 1'b1;
                        r_accepted <= 1'b0;
                        r_addr     <= req_addr;
                        r_data     <= w_lane_data;
                        r_strobe   <= w_lane_strobe;
                        r_size     <= {1'b0, req_msize};
                    end
                end
                c_st_req: begin
                    if (dresp_addr_ok) begin
                        r_accepted <= 1'b1;
                    end
                    if (dresp_data_ok) begin
                        r_state <= c_st_done;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (flush && !(r_accepted || dresp_addr_ok)) begin
                        // Once the bus has the address it owns the write, so
                        // a flush can only cancel a not-yet-accepted request.
                        r_state <= c_st_idle;
                        r_valid <= 1'b0;
                    end else if (w_expire) begin
                        r_state   <= c_st_idle;
                        r_valid   <= 1'b0;
                        r_bus_err <= 1'b1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dreq_valid  = r_valid;
    assign dreq_addr   = r_addr;
    assign dreq_size   = r_size;
    assign dreq_strobe = r_strobe;
    assign dreq_data   = r_data;
    assign done        = r_done;
    assign bus_err     = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_store_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_issue
// Purpose  : Self-checking bench for store_issue. Stimulus pushes expected
//            bus events into a queue; a monitor pops and compares them as the
//            DUT presents requests, done pulses, bus errors and exceptions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_issue;

    localparam int c_timeout = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_msize;
    logic        flush;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic        stall;
    logic        done;
    logic        st_misalign;
    logic        bus_err;

    store_issue #(.TIMEOUT_CYCLES(c_timeout)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_msize     (req_msize),
        .flush         (flush),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .stall         (stall),
        .done          (done),
        .st_misalign   (st_misalign),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_REQ, EV_DONE, EV_BERR, EV_MIS} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strobe;
        logic [2:0]  size;
    } ev_t;

    ev_t expq[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  stall_cycles = 0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void exp_ev(input ev_kind_t k, input logic [63:0] a, input logic [63:0] d,
                                   input logic [7:0] s, input logic [2:0] z);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.strobe = s; e.size = z;
        expq.push_back(e);
    endfunction

    function automatic bit pop_ev(input ev_kind_t k, input string nm, output ev_t e);
        n_cmp++;
        e.kind = k; e.addr = '0; e.data = '0; e.strobe = '0; e.size = '0;
        if (expq.size() == 0) begin
            n_bad++;
            $display("FAIL %s: unexpected event, expected queue empty", nm);
            return 1'b0;
        end
        if (expq[0].kind != k) begin
            n_bad++;
            $display("FAIL %s: got event %0d, expected event %0d", nm, k, expq[0].kind);
            return 1'b0;
        end
        e = expq.pop_front();
        return 1'b1;
    endfunction

    // ---------------- monitor ----------------
    logic        mon_prev_v = 1'b0;
    logic [63:0] mon_addr, mon_data;
    logic [7:0]  mon_strobe;
    logic [2:0]  mon_size;

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (dreq_valid && !mon_prev_v) begin
                if (pop_ev(EV_REQ, "req_issue", e)) begin
                    check("req_addr",   dreq_addr,   e.addr);
                    check("req_data",   dreq_data,   e.data);
                    check("req_strobe", {56'd0, dreq_strobe}, {56'd0, e.strobe});
                    check("req_size",   {61'd0, dreq_size},   {61'd0, e.size});
                end
                mon_addr = dreq_addr; mon_data = dreq_data;
                mon_strobe = dreq_strobe; mon_size = dreq_size;
            end else if (dreq_valid) begin
                check("hold_addr",   dreq_addr, mon_addr);
                check("hold_data",   dreq_data, mon_data);
                check("hold_strobe", {56'd0, dreq_strobe}, {56'd0, mon_strobe});
                check("hold_size",   {61'd0, dreq_size},   {61'd0, mon_size});
            end
            if (done)        void'(pop_ev(EV_DONE, "done_pulse", e));
            if (bus_err)     void'(pop_ev(EV_BERR, "bus_err_pulse", e));
            if (st_misalign) void'(pop_ev(EV_MIS, "st_misalign", e));
            mon_prev_v = dreq_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [63:0] a, input logic [63:0] d, input logic [1:0] m);
        req_valid = 1'b1; req_addr = a; req_data = d; req_msize = m;
    endtask

    // Issue cycle in IDLE: stall must rise combinationally, then enter REQ.
    task automatic issue(input string nm, input logic [63:0] a, input logic [63:0] d, input logic [1:0] m);
        drive_req(a, d, m);
        #1;
        check({nm, "_issue_stall"}, {63'd0, stall}, 64'd1);
        @(negedge clk);
        if (stall) stall_cycles++;
        step();
        req_valid = 1'b0;
    endtask

    // Drive n REQ cycles; ao/dok/fl give the cycle index of each pulse (-1 = never).
    task automatic run_req(input string nm, input int ao, input int dok, input int fl, input int n);
        for (int i = 0; i < n; i++) begin
            dresp_addr_ok = (i == ao);
            dresp_data_ok = (i == dok);
            flush         = (i == fl);
            @(negedge clk);
            if (stall) stall_cycles++;
            check({nm, "_req_valid"}, {63'd0, dreq_valid}, 64'd1);
            step();
        end
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_valid"},  {63'd0, dreq_valid}, 64'd0);
        check({nm, "_addr"},   dreq_addr, 64'd0);
        check({nm, "_size"},   {61'd0, dreq_size}, 64'd0);
        check({nm, "_strobe"}, {56'd0, dreq_strobe}, 64'd0);
        check({nm, "_data"},   dreq_data, 64'd0);
        check({nm, "_stall"},  {63'd0, stall}, 64'd0);
        check({nm, "_done"},   {63'd0, done}, 64'd0);
        check({nm, "_mis"},    {63'd0, st_misalign}, 64'd0);
        check({nm, "_berr"},   {63'd0, bus_err}, 64'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_msize = '0;
        flush = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        repeat (2) step();
        check_all_zero("reset_state");
        reset = 1'b0;
        step();

        // sb at offset 3, data_ok in the second REQ cycle
        stall_cycles = 0;
        exp_ev(EV_REQ, 64'h80000003, 64'h00000000AB000000, 8'h08, 3'd0);
        exp_ev(EV_DONE, '0, '0, '0, '0);
        issue("sb", 64'h80000003, 64'hAB, 2'd0);
        run_req("sb", -1, 1, -1, 2);
        check("sb_done_stall", {63'd0, stall}, 64'd0);
        check("sb_done_valid", {63'd0, dreq_valid}, 64'd0);
        check("sb_stall_cycles", 64'(stall_cycles), 64'd3);
        step();

        // sd, addr_ok and data_ok together in the first REQ cycle
        exp_ev(EV_REQ, 64'h80000010, 64'h1122334455667788, 8'hFF, 3'd3);
        exp_ev(EV_DONE, '0, '0, '0, '0);
        issue("sd", 64'h80000010, 64'h1122334455667788, 2'd3);
        run_req("sd", 0, 0, -1, 1);
        check("sd_done", {63'd0, done}, 64'd1);
        step();

        // misaligned sw: exception only, no bus request
        exp_ev(EV_MIS, '0, '0, '0, '0);
        drive_req(64'h80000006, 64'h12345678, 2'd2);
        #1;
        check("sw_mis_flag", {63'd0, st_misalign}, 64'd1);
        check("sw_mis_stall", {63'd0, stall}, 64'd0);
        step();
        req_valid = 1'b0;
        check("sw_mis_novalid", {63'd0, dreq_valid}, 64'd0);
        step();
        check("sw_mis_novalid2", {63'd0, dreq_valid}, 64'd0);

        // sh at offset 6 is aligned
        exp_ev(EV_REQ, 64'h80000006, 64'hBEEF000000000000, 8'hC0, 3'd1);
        exp_ev(EV_DONE, '0, '0, '0, '0);
        drive_req(64'h80000006, 64'hBEEF, 2'd1);
        #1;
        check("sh6_no_mis", {63'd0, st_misalign}, 64'd0);
        issue("sh6", 64'h80000006, 64'hBEEF, 2'd1);
        run_req("sh6", -1, 0, -1, 1);
        step();

        // flush before addr_ok: dropped, no done
        exp_ev(EV_REQ, 64'h80000040, 64'h000000000000CAFE, 8'h03, 3'd1);
        issue("shfl", 64'h80000040, 64'hCAFE, 2'd1);
        run_req("shfl", -1, -1, 0, 1);
        check("shfl_valid", {63'd0, dreq_valid}, 64'd0);
        check("shfl_stall", {63'd0, stall}, 64'd0);
        check("shfl_done", {63'd0, done}, 64'd0);
        step();

        // flush after addr_ok: write still completes
        exp_ev(EV_REQ, 64'h80000042, 64'h0000000012340000, 8'h0C, 3'd1);
        exp_ev(EV_DONE, '0, '0, '0, '0);
        issue("shfa", 64'h80000042, 64'h1234, 2'd1);
        run_req("shfa", 0, 2, 1, 3);
        check("shfa_done", {63'd0, done}, 64'd1);
        step();

        // timeout with no bus response
        exp_ev(EV_REQ, 64'h80000080, 64'h0000000000000055, 8'h01, 3'd0);
        exp_ev(EV_BERR, '0, '0, '0, '0);
        issue("tmo", 64'h80000080, 64'h55, 2'd0);
        run_req("tmo", -1, -1, -1, 4);
        check("tmo_berr", {63'd0, bus_err}, 64'd1);
        check("tmo_valid", {63'd0, dreq_valid}, 64'd0);
        check("tmo_stall", {63'd0, stall}, 64'd0);
        step();

        // data_ok on the expiry cycle wins
        exp_ev(EV_REQ, 64'h80000088, 64'h0000000000000066, 8'h01, 3'd0);
        exp_ev(EV_DONE, '0, '0, '0, '0);
        issue("tmok", 64'h80000088, 64'h66, 2'd0);
        run_req("tmok", -1, 3, -1, 4);
        check("tmok_done", {63'd0, done}, 64'd1);
        check("tmok_berr", {63'd0, bus_err}, 64'd0);
        step();

        // reset in the middle of REQ
        exp_ev(EV_REQ, 64'h80000020, 64'h00000000DEADBEEF, 8'h0F, 3'd2);
        issue("rst", 64'h80000020, 64'hDEADBEEF, 2'd2);
        run_req("rst", -1, -1, -1, 1);
        reset = 1'b1;
        step();
        check_all_zero("rst_midreq");
        reset = 1'b0;
        step();

        // back-to-back sb: second request held through DONE, taken in IDLE
        exp_ev(EV_REQ, 64'h80000101, 64'h0000000000005A00, 8'h02, 3'd0);
        exp_ev(EV_DONE, '0, '0, '0, '0);
        exp_ev(EV_REQ, 64'h80000107, 64'h7700000000000000, 8'h80, 3'd0);
        exp_ev(EV_DONE, '0, '0, '0, '0);
        issue("b2b1", 64'h80000101, 64'h5A, 2'd0);
        run_req("b2b1", 1, 2, -1, 3);
        drive_req(64'h80000107, 64'h77, 2'd0);
        #1;
        check("b2b_done_stall", {63'd0, stall}, 64'd0);
        check("b2b_done_valid", {63'd0, dreq_valid}, 64'd0);
        step();
        issue("b2b2", 64'h80000107, 64'h77, 2'd0);
        run_req("b2b2", -1, 0, -1, 1);
        step();
        step();

        check("queue_empty", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
